imem_loader: RTL and testbench

//  Write-side counterpart of the byte-addressed instruction memory. It receives a

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
// Contents: loader FSM state encoding, frame framing constants.
// No logic; imported by imem_loader.
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Frame overhead around the payload: 16-bit big-endian length header, XOR checksum trailer.
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  // A byte is only consumed in the header, payload and checksum states.
  function automatic logic st_accepts(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed program image from a byte
//   stream into byte-addressed instruction memory (byte k -> address k) and holds
//   the CPU until a verified image is present.
// Latency: a payload byte accepted on edge t is written (mem_we) during cycle t..t+1;
//   done/err assert the cycle after the checksum byte is accepted.
// Backpressure: in_ready is registered and high only while a frame is in progress;
//   in_valid low simply stalls with no side effects.
// Ports:
//   clk, rst (async active-high), start (1-cycle pulse)
//   in_valid / in_data / in_ready : byte stream in
//   mem_we / mem_addr / mem_wdata  : registered memory byte write port
//   cpu_hold, done, err            : status levels; byte_count : payload bytes written
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [16:0] LP_MAX_LEN = 17'(MEM_BYTES);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [7:0]        r_acc;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_hold;

  state_t            w_nxt;
  logic              w_xfer;
  logic [15:0]       w_len_n;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_len_bad;

  assign w_xfer    = in_valid && r_in_ready;
  // Full length as it will be once the low byte currently on the bus is taken.
  assign w_len_n   = {r_len[15:8], in_data};
  assign w_cnt_inc = r_cnt + 1'b1;
  // Images must fit in memory and be a whole number of 32-bit instruction words.
  assign w_len_bad = ({1'b0, w_len_n} > LP_MAX_LEN) || (w_len_n[1:0] != 2'b00);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) w_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len_bad)              w_nxt = ST_ERR;
          else if (w_len_n == 16'd0)  w_nxt = ST_CSUM;
          else                        w_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer && (16'(w_cnt_inc) == r_len)) w_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_xfer) w_nxt = (in_data == r_acc) ? ST_DONE : ST_ERR;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= st_accepts(w_nxt);
      r_done     <= (w_nxt == ST_DONE);
      r_err      <= (w_nxt == ST_ERR);
      r_cpu_hold <= (w_nxt != ST_DONE);
      r_we       <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        ST_LEN_HI: begin
          if (w_xfer) r_len[15:8] <= in_data;
        end
        ST_LEN_LO: begin
          if (w_xfer) r_len[7:0] <= in_data;
        end
        ST_DATA: begin
          if (w_xfer) begin
            // Write index is the count before increment, so byte k lands at address k.
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= in_data;
            r_acc   <= r_acc ^ in_data;
            r_cnt   <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign byte_count = r_cnt;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [9:0] byte_count;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] pay [512];
  logic [8:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         wr_cyc  [$];

  imem_loader #(.MEM_BYTES(512), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called on a negedge; returns on the negedge after the byte was taken.
  task automatic send(input logic [7:0] b, input int gap);
    bit accepted;
    accepted = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'h5A;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 64; k++) begin
      if (in_ready === 1'b1) begin
        @(negedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) check("send_accept", {31'd0, accepted}, 32'd1);
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input int from, input int to, input int max_gap);
    for (int i = from; i < to; i++) send(pay[i], pick_gap(max_gap));
  endtask

  task automatic run_frame(input logic [15:0] len, input int npay,
                           input logic [7:0] csum, input int max_gap);
    send(len[15:8], pick_gap(max_gap));
    send(len[7:0], pick_gap(max_gap));
    send_bytes(0, npay, max_gap);
    send(csum, pick_gap(max_gap));
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input bit need_consecutive);
    int bad;
    int gaps;
    bad = 0;
    gaps = 0;
    check({tag, "_wr_count"}, wr_addr.size(), n);
    for (int i = 0; i < wr_addr.size() && i < n; i++) begin
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== pay[i]) bad++;
      if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
    end
    check({tag, "_wr_content_errs"}, bad, 0);
    if (need_consecutive) check({tag, "_wr_gaps"}, gaps, 0);
  endtask

  function automatic logic [7:0] xor_model(input int n);
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < n; i++) a = a ^ pay[i];
    return a;
  endfunction

  task automatic load_nominal_payload();
    pay[0] = 8'h24; pay[1] = 8'h01; pay[2] = 8'h00; pay[3] = 8'h05;
    pay[4] = 8'h24; pay[5] = 8'h1F; pay[6] = 8'h00; pay[7] = 8'h00;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    load_nominal_payload();

    // Reset values with reset asserted.
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_byte_count", byte_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);

    // Asynchronous reset in the middle of DATA, right after a write.
    pulse_start();
    send(8'h00, 0); send(8'h08, 0);
    send_bytes(0, 3, 0);
    check("mid_mem_we", mem_we, 1);
    check("mid_byte_count", byte_count, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_cpu_hold", cpu_hold, 1);
    check("arst_byte_count", byte_count, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    in_valid = 1'b1; in_data = 8'h77;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_no_wr", wr_addr.size(), 0);
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_hold", cpu_hold, 1);

    // Nominal 8-byte image; XOR of 24 01 00 05 24 1F 00 00 is 1B.
    clear_log();
    pulse_start();
    run_frame(16'h0008, 8, 8'h1B, 0);
    check("nom_done", done, 1);
    check("nom_err", err, 0);
    check("nom_cpu_hold", cpu_hold, 0);
    check("nom_byte_count", byte_count, 8);
    check("nom_in_ready", in_ready, 0);
    check_writes("nom", 8, 1'b1);

    // Same payload, wrong checksum byte.
    clear_log();
    pulse_start();
    check("restart_done_clr", done, 0);
    run_frame(16'h0008, 8, 8'h2C, 0);
    check("badcs_err", err, 1);
    check("badcs_done", done, 0);
    check("badcs_cpu_hold", cpu_hold, 1);
    check_writes("badcs", 8, 1'b1);

    // Length beyond memory.
    clear_log();
    pulse_start();
    check("restart_err_clr", err, 0);
    send(8'h02, 0); send(8'h01, 0);
    in_valid = 1'b0;
    check("len_big_err", err, 1);
    check("len_big_in_ready", in_ready, 0);
    check("len_big_done", done, 0);
    // Length not a word multiple.
    pulse_start();
    send(8'h00, 0); send(8'h06, 0);
    in_valid = 1'b0;
    check("len_odd_err", err, 1);
    check("len_odd_cpu_hold", cpu_hold, 1);
    repeat (2) @(negedge clk);
    check("len_bad_no_wr", wr_addr.size(), 0);

    // Empty image: checksum of nothing is 00.
    clear_log();
    pulse_start();
    run_frame(16'h0000, 0, 8'h00, 0);
    check("len0_done", done, 1);
    check("len0_no_wr", wr_addr.size(), 0);

    // Full-size image at full throughput.
    for (int i = 0; i < 512; i++) pay[i] = 8'((i * 37 + 11) ^ (i >> 3));
    clear_log();
    pulse_start();
    run_frame(16'h0200, 512, xor_model(512), 0);
    check("full_done", done, 1);
    check("full_byte_count", byte_count, 512);
    check_writes("full", 512, 1'b1);
    if (wr_addr.size() > 0) check("full_last_addr", wr_addr[wr_addr.size()-1], 511);

    // Random stalls, and a start pulse mid-DATA that must be ignored.
    load_nominal_payload();
    clear_log();
    pulse_start();
    send(8'h00, pick_gap(3)); send(8'h08, pick_gap(3));
    send_bytes(0, 4, 3);
    in_valid = 1'b0;
    pulse_start();
    check("start_in_data_cnt", byte_count, 4);
    check("start_in_data_rdy", in_ready, 1);
    send_bytes(4, 8, 3);
    send(8'h1B, pick_gap(3));
    in_valid = 1'b0;
    check("stall_done", done, 1);
    check_writes("stall", 8, 1'b0);

    // Restart from DONE and reload.
    clear_log();
    pulse_start();
    check("reload_done_clr", done, 0);
    check("reload_in_ready", in_ready, 1);
    check("reload_hold", cpu_hold, 1);
    run_frame(16'h0008, 8, 8'h1B, 2);
    check("reload_done", done, 1);
    check_writes("reload", 8, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
